// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: branch resolve, req/ack data-memory
// access with timeout abort, and the MEM/WB pipeline latch.
module mem_stage #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  m_ctl,
  input  logic [1:0]  wb_ctl,
  input  logic [31:0] branch_target,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_reg,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] pc_target,
  output logic [1:0]  wb_ctl_out,
  output logic [31:0] read_data,
  output logic [31:0] alu_out,
  output logic [4:0]  wb_reg,
  output logic        bus_err
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  counter;
  logic        mem_op;
  logic        complete;
  logic        abort;

  assign mem_op    = m_ctl[1] | m_ctl[0];
  assign pcsrc     = m_ctl[2] & zero;
  assign pc_target = branch_target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An ack arriving in the timeout cycle wins, so abort is only raised without ack.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          stall      = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          complete   = 1'b1;
          next_state = S_IDLE;
        end else if (counter >= LAST_WAIT) begin
          complete   = 1'b1;
          abort      = 1'b1;
          next_state = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter    <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      wb_ctl_out <= 2'b00;
      read_data  <= 32'd0;
      alu_out    <= 32'd0;
      wb_reg     <= 5'd0;
      bus_err    <= 1'b0;
    end else if (state == S_IDLE) begin
      if (mem_op) begin
        dmem_req   <= 1'b1;
        dmem_we    <= m_ctl[0];
        dmem_addr  <= {alu_result[31:2], 2'b00};
        dmem_wdata <= write_data;
        counter    <= 8'd0;
        wb_ctl_out <= 2'b00;
      end else begin
        wb_ctl_out <= wb_ctl;
        alu_out    <= alu_result;
        wb_reg     <= write_reg;
      end
    end else if (complete) begin
      dmem_req   <= 1'b0;
      wb_ctl_out <= wb_ctl;
      alu_out    <= alu_result;
      wb_reg     <= write_reg;
      if (!dmem_we) begin
        read_data <= abort ? ERR_DATA : dmem_rdata;
      end
      if (abort) begin
        bus_err <= 1'b1;
      end
    end else begin
      wb_ctl_out <= 2'b00;
      if (counter < LAST_WAIT) begin
        counter <= counter + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_stage;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  m_ctl = 3'b000;
  logic [1:0]  wb_ctl = 2'b00;
  logic [31:0] branch_target = 32'd0;
  logic        zero = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [4:0]  write_reg = 5'd0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;
  logic        dmem_req, dmem_we, stall, pcsrc, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, pc_target, read_data, alu_out;
  logic [1:0]  wb_ctl_out;
  logic [4:0]  wb_reg;

  int checks = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .m_ctl(m_ctl), .wb_ctl(wb_ctl),
    .branch_target(branch_target), .zero(zero), .alu_result(alu_result),
    .write_data(write_data), .write_reg(write_reg), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .stall(stall),
    .pcsrc(pcsrc), .pc_target(pc_target), .wb_ctl_out(wb_ctl_out),
    .read_data(read_data), .alu_out(alu_out), .wb_reg(wb_reg), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an access is "busy" after detect; waits counts finished WAIT cycles.
  logic        m_busy, m_req, m_we, m_err;
  int          m_waits;
  logic [31:0] m_addr, m_wdata, m_rdata, m_alu;
  logic [1:0]  m_wbctl;
  logic [4:0]  m_reg;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_waits <= 0; m_req <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
      m_addr <= 32'd0; m_wdata <= 32'd0; m_rdata <= 32'd0; m_alu <= 32'd0;
      m_wbctl <= 2'b00; m_reg <= 5'd0;
    end else if (!m_busy) begin
      if (m_ctl[1] || m_ctl[0]) begin
        m_busy <= 1'b1; m_waits <= 0; m_req <= 1'b1; m_we <= m_ctl[0];
        m_addr <= alu_result & 32'hFFFF_FFFC; m_wdata <= write_data; m_wbctl <= 2'b00;
      end else begin
        m_wbctl <= wb_ctl; m_alu <= alu_result; m_reg <= write_reg;
      end
    end else if (dmem_ack || (m_waits + 1 == TO)) begin
      m_busy <= 1'b0; m_req <= 1'b0;
      m_wbctl <= wb_ctl; m_alu <= alu_result; m_reg <= write_reg;
      if (!m_we) m_rdata <= dmem_ack ? dmem_rdata : ERR;
      if (!dmem_ack) m_err <= 1'b1;
    end else begin
      m_waits <= m_waits + 1;
      m_wbctl <= 2'b00;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      logic exp_stall;
      exp_stall = m_busy ? !(dmem_ack || (m_waits + 1 == TO)) : (m_ctl[1] || m_ctl[0]);
      checkOutput("model_stall", {31'd0, stall}, {31'd0, exp_stall});
      checkOutput("model_pcsrc", {31'd0, pcsrc}, {31'd0, m_ctl[2] & zero});
      checkOutput("model_pc_target", pc_target, branch_target);
      checkOutput("model_dmem_req", {31'd0, dmem_req}, {31'd0, m_req});
      checkOutput("model_dmem_we", {31'd0, dmem_we}, {31'd0, m_we});
      checkOutput("model_dmem_addr", dmem_addr, m_addr);
      checkOutput("model_dmem_wdata", dmem_wdata, m_wdata);
      checkOutput("model_wb_ctl_out", {30'd0, wb_ctl_out}, {30'd0, m_wbctl});
      checkOutput("model_read_data", read_data, m_rdata);
      checkOutput("model_alu_out", alu_out, m_alu);
      checkOutput("model_wb_reg", {27'd0, wb_reg}, {27'd0, m_reg});
      checkOutput("model_bus_err", {31'd0, bus_err}, {31'd0, m_err});
    end
  end

  task automatic applyStimulus(input logic [2:0] mc, input logic [1:0] wbc, input logic [31:0] bt,
                               input logic z, input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] wr);
    m_ctl = mc; wb_ctl = wbc; branch_target = bt; zero = z;
    alu_result = alu; write_data = wd; write_reg = wr;
  endtask

  task automatic applyNop();
    applyStimulus(3'b000, 2'b00, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  logic [31:0] seen_addr, seen_wdata;
  logic        seen_we;

  // Runs one access; ack_at is the WAIT cycle carrying the ack (0 = never).
  task automatic doMemOp(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] wbc, input logic [4:0] wreg, input int ack_at,
                         input logic [31:0] rdata, output int stall_cycles);
    applyStimulus({1'b0, ~wr, wr}, wbc, 32'd0, 1'b0, addr, data, wreg);
    stall_cycles = 0;
    for (int k = 0; k < 300; k++) begin
      dmem_ack   = (ack_at > 0) && (k == ack_at);
      dmem_rdata = rdata;
      if (k == 1) begin
        seen_addr = dmem_addr; seen_we = dmem_we; seen_wdata = dmem_wdata;
      end
      #2;
      if (!stall) break;
      stall_cycles++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    applyNop();
  endtask

  int sc;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #12;
    checkOutput("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("reset_bus_err", {31'd0, bus_err}, 32'd0);
    checkOutput("reset_wb_ctl_out", {30'd0, wb_ctl_out}, 32'd0);
    checkOutput("reset_read_data", read_data, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    #2 checkOutput("idle_stall", {31'd0, stall}, 32'd0);

    doMemOp(1'b0, 32'h104, 32'd0, 2'b11, 5'd8, 1, 32'hCAFEF00D, sc);
    checkOutput("load_stall_cycles", sc, 1);
    checkOutput("load_addr", seen_addr, 32'h104);
    checkOutput("load_we", {31'd0, seen_we}, 32'd0);
    checkOutput("load_read_data", read_data, 32'hCAFEF00D);
    checkOutput("load_wb_reg", {27'd0, wb_reg}, 32'd8);
    checkOutput("load_wb_ctl", {30'd0, wb_ctl_out}, 32'd3);

    doMemOp(1'b1, 32'h203, 32'h12345678, 2'b00, 5'd0, 3, 32'h55555555, sc);
    checkOutput("store_stall_cycles", sc, 3);
    checkOutput("store_addr", seen_addr, 32'h200);
    checkOutput("store_we", {31'd0, seen_we}, 32'd1);
    checkOutput("store_wdata", seen_wdata, 32'h12345678);
    checkOutput("store_read_data_held", read_data, 32'hCAFEF00D);

    applyStimulus(3'b100, 2'b00, 32'h40, 1'b1, 32'd0, 32'd0, 5'd0);
    #2;
    checkOutput("branch_pcsrc", {31'd0, pcsrc}, 32'd1);
    checkOutput("branch_target", pc_target, 32'h40);
    checkOutput("branch_stall", {31'd0, stall}, 32'd0);
    zero = 1'b0;
    #1 checkOutput("branch_not_taken", {31'd0, pcsrc}, 32'd0);
    @(posedge clk); #1;
    applyNop();

    doMemOp(1'b0, 32'h300, 32'd0, 2'b11, 5'd5, 1, 32'hAAAA0001, sc);
    checkOutput("b2b_first_cycles", sc, 1);
    checkOutput("b2b_first_reg", {27'd0, wb_reg}, 32'd5);
    doMemOp(1'b0, 32'h304, 32'd0, 2'b11, 5'd6, 1, 32'hAAAA0002, sc);
    checkOutput("b2b_second_cycles", sc, 1);
    checkOutput("b2b_second_reg", {27'd0, wb_reg}, 32'd6);
    checkOutput("b2b_second_data", read_data, 32'hAAAA0002);

    doMemOp(1'b0, 32'h400, 32'd0, 2'b11, 5'd9, TO, 32'h0BADF00D, sc);
    checkOutput("ack_on_timeout_cycles", sc, TO);
    checkOutput("ack_on_timeout_bus_err", {31'd0, bus_err}, 32'd0);
    checkOutput("ack_on_timeout_data", read_data, 32'h0BADF00D);

    doMemOp(1'b0, 32'h500, 32'd0, 2'b11, 5'd10, 0, 32'h77777777, sc);
    checkOutput("timeout_stall_cycles", sc, TO);
    checkOutput("timeout_read_data", read_data, 32'hDEADBEEF);
    checkOutput("timeout_bus_err", {31'd0, bus_err}, 32'd1);
    checkOutput("timeout_dmem_req", {31'd0, dmem_req}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    checkOutput("stray_ack_read_data", read_data, 32'hDEADBEEF);
    checkOutput("stray_ack_bus_err", {31'd0, bus_err}, 32'd1);
    checkOutput("stray_ack_dmem_req", {31'd0, dmem_req}, 32'd0);

    applyStimulus(3'b010, 2'b11, 32'd0, 1'b0, 32'h600, 32'd0, 5'd3);
    @(posedge clk); #1;
    checkOutput("pre_reset_req", {31'd0, dmem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midwait_reset_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("midwait_reset_wb_ctl", {30'd0, wb_ctl_out}, 32'd0);
    checkOutput("midwait_reset_bus_err", {31'd0, bus_err}, 32'd0);
    applyNop();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    #2;
    checkOutput("post_reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("post_reset_req", {31'd0, dmem_req}, 32'd0);

    doMemOp(1'b0, 32'h708, 32'd0, 2'b10, 5'd12, 2, 32'h13579BDF, sc);
    checkOutput("post_reset_load_cycles", sc, 2);
    checkOutput("post_reset_load_data", read_data, 32'h13579BDF);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline: consumes the EX/MEM latch (control, branch target, zero, ALU result, store data, destination register), resolves the branch, performs loads/stores over a req/ack data-memory port, and drives the MEM/WB latch. It stalls upstream stages while a memory access is outstanding and aborts accesses that exceed a timeout.

## Interface
- TIMEOUT, 255: max WAIT cycles without ack before abort (1..255).
- ERR_DATA, 32'hDEADBEEF: read_data value loaded on timed-out load.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- m_ctl  in  3  {branch, memread, memwrite}
- wb_ctl  in  2  {regwrite, memtoreg}
- branch_target  in  32  branch target from EX adder
- zero  in  1  ALU zero flag
- alu_result  in  32  ALU result / memory address
- write_data  in  32  store data
- write_reg  in  5  destination register
- dmem_rdata  in  32  memory read data
- dmem_ack  in  1  memory completion, 1-cycle pulse
- dmem_req  out  1  access request (registered)
- dmem_we  out  1  1 = write (registered)
- dmem_addr  out  32  word address {alu_result[31:2],2'b00} (registered)
- dmem_wdata  out  32  store data (registered)
- stall  out  1  holds PC, IF/ID, ID/EX, EX/MEM (combinational)
- pcsrc  out  1  take branch (combinational)
- pc_target  out  32  = branch_target
- wb_ctl_out  out  2  MEM/WB control
- read_data  out  32  MEM/WB load data
- alu_out  out  32  MEM/WB ALU result
- wb_reg  out  5  MEM/WB destination
- bus_err  out  1  sticky, set on timeout

## Operation
- mem_op = memread | memwrite. Both set: treated as write.
- pcsrc = branch & zero, independent of state.
- FSM states: IDLE, WAIT.
- IDLE, !mem_op: stall=0; MEM/WB loads wb_ctl, alu_result, write_reg; read_data holds.
- IDLE, mem_op: stall=1; MEM/WB loads bubble (wb_ctl_out=0, others hold); next edge dmem_req<=1, dmem_we/addr/wdata captured, counter<=0, ->WAIT.
- WAIT, !ack, counter<TIMEOUT-1: stall=1, bubble, counter++, dmem_* stable.
- WAIT, ack: stall=0; edge: read_data<=dmem_rdata if load (holds if store), wb_ctl_out/alu_out/wb_reg loaded, dmem_req<=0, ->IDLE.
- WAIT, !ack, counter==TIMEOUT-1: stall=0; edge: completes as ack with read_data<=ERR_DATA (loads), bus_err<=1, dmem_req<=0, ->IDLE.
- dmem_ack outside WAIT ignored. Ack and timeout in same cycle: ack wins, bus_err unchanged.
- bus_err cleared only by reset.
- Counter 8-bit, never wraps.

## Timing
- Reset (async assert, sync release): state IDLE, all registered outputs 0, bus_err 0, counter 0; dmem_req drops immediately even mid-access.
- Non-memory instruction: 1 cycle, MEM/WB valid after next edge.
- Memory op: min 2 cycles (IDLE detect + 1 WAIT with ack); with ack in Nth WAIT cycle, N+1 cycles total; stall high for first N cycles.
- dmem_req rises one edge after detect; earliest valid ack is first WAIT cycle.
- Timeout: stall high TIMEOUT cycles, abort in TIMEOUT-th WAIT cycle.
- EX/MEM inputs must hold while stall=1 (upstream responsibility).

## Test plan
- Reset mid-WAIT: assert reset with dmem_req=1 -> dmem_req, wb_ctl_out, bus_err 0 immediately; state IDLE after release.
- Load alu_result=0x104, wb_ctl=2'b11, write_reg=8, ack in 1st WAIT with rdata=0xCAFEF00D -> stall high 1 cycle, dmem_addr=0x104, dmem_we=0; then read_data=0xCAFEF00D, wb_reg=8, wb_ctl_out=2'b11.
- Store addr=0x203 data=0x12345678, ack after 3 WAIT cycles -> dmem_addr=0x200, dmem_we=1, dmem_wdata=0x12345678, stall high 3 cycles, read_data unchanged.
- Branch, m_ctl=3'b100, zero=1, branch_target=0x40 -> pcsrc=1, pc_target=0x40, stall=0; zero=0 -> pcsrc=0.
- TIMEOUT=4 load, no ack -> stall high 4 cycles, then read_data=0xDEADBEEF, bus_err=1, dmem_req=0; later ack ignored; bus_err persists.
- Back-to-back loads, ack in each 1st WAIT -> each takes 2 cycles, MEM/WB shows load1, bubble, load2 in order; ack on timeout cycle -> bus_err stays 0.
